timer: RTL and testbench



---
 rtl/timer_pkg.sv | 19 +
 rtl/timer.sv | 51 +++++
 tb/tb_timer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared clocking constants and helpers for time-base blocks such as timer.
// Instantiators can derive a tick period in clocks as CLK_HZ * period_seconds.
package timer_pkg;

  // System clock frequency in Hz.
  localparam int unsigned CLK_HZ = 32'd50_000_000;

  // Terminal count for a period of cyc clocks; a period of 0 behaves as 1.
  function automatic logic [31:0] last_count(input logic [31:0] cyc);
    logic [31:0] last;
    if (cyc == 32'd0) begin
      last = 32'd0;
    end else begin
      last = cyc - 32'd1;
    end
    return last;
  endfunction

endpackage : timer_pkg

// File: rtl/timer.sv
// Free-running periodic tick generator: divides clk by `cycle` and emits a
// registered one-clock pulse `cy` once per period. `count` exposes the phase.
module timer
  import timer_pkg::*;
#(
  parameter logic [31:0] cycle = 32'd50_000_000,
  parameter int          WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             cy,
  output logic [WIDTH-1:0] count
);

  // Last counter value of a period; cycle==0 collapses to a period of 1.
  localparam logic [WIDTH-1:0] LAST = WIDTH'(last_count(cycle));
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             cy_q,  cy_d;

  // Next-state: wrap to zero and fire the pulse at the terminal count.
  // The >= compare also recovers cleanly should the counter ever be upset
  // beyond LAST, instead of running the full WIDTH range.
  always_comb begin
    cnt_d = cnt_q;
    cy_d  = 1'b0;
    if (cnt_q >= LAST) begin
      cnt_d = '0;
      cy_d  = 1'b1;
    end else begin
      cnt_d = cnt_q + ONE;
      cy_d  = 1'b0;
    end
  end

  // State registers with synchronous, dominant reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      cy_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      cy_q  <= cy_d;
    end
  end

  assign cy    = cy_q;
  assign count = cnt_q;

endmodule : timer

// File: tb/tb_timer.sv
// Self-checking bench for timer: four instances (cycle 5, 1, 0 and 41667)
// compared every clock against a model based on "edges since reset release".
module tb_timer;

  logic        clk = 1'b0;
  logic [3:0]  rst_v = 4'hF;
  logic [3:0]  cy_v;
  logic [31:0] cnt5, cnt1, cnt0;
  logic [15:0] cnt_big;

  int checks   = 0;
  int failures = 0;

  // Model state: period per instance and edges since the last reset edge.
  int unsigned per_v [4] = '{32'd5, 32'd1, 32'd1, 32'd41_667};
  int unsigned k_v   [4] = '{32'd0, 32'd0, 32'd0, 32'd0};
  bit          valid_v [4] = '{1'b0, 1'b0, 1'b0, 1'b0};

  // Pulse window statistics for the cycle=5 instance.
  bit win_on      = 1'b0;
  int win_edge    = 0;
  int win_pulses  = 0;
  int last_pulse  = -1;

  // Long-period instance statistics.
  int unsigned big_first  = 0;
  int unsigned big_second = 0;
  int unsigned big_max    = 0;

  always #5 clk = ~clk;

  timer #(.cycle(32'd5), .WIDTH(32)) u_c5 (
    .clk(clk), .rst(rst_v[0]), .cy(cy_v[0]), .count(cnt5));
  timer #(.cycle(32'd1), .WIDTH(32)) u_c1 (
    .clk(clk), .rst(rst_v[1]), .cy(cy_v[1]), .count(cnt1));
  timer #(.cycle(32'd0), .WIDTH(32)) u_c0 (
    .clk(clk), .rst(rst_v[2]), .cy(cy_v[2]), .count(cnt0));
  timer #(.cycle(32'd41_667), .WIDTH(16)) u_big (
    .clk(clk), .rst(rst_v[3]), .cy(cy_v[3]), .count(cnt_big));

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint obs_count(input int i);
    longint v;
    case (i)
      0:       v = longint'(cnt5);
      1:       v = longint'(cnt1);
      2:       v = longint'(cnt0);
      default: v = longint'(cnt_big);
    endcase
    return v;
  endfunction

  // Drive resets away from the edge, then check all instances just after it.
  task automatic step(input logic [3:0] r);
    int unsigned exp_cnt;
    bit          exp_cy;
    @(negedge clk);
    rst_v = r;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (r[i]) begin
        k_v[i]     = 0;
        valid_v[i] = 1'b1;
        exp_cnt    = 0;
        exp_cy     = 1'b0;
      end else begin
        k_v[i]++;
        exp_cnt = k_v[i] % per_v[i];
        exp_cy  = (exp_cnt == 0);
      end
      if (valid_v[i]) begin
        check($sformatf("count[%0d]", i), obs_count(i), longint'(exp_cnt));
        check($sformatf("cy[%0d]", i), longint'(cy_v[i]), longint'(exp_cy));
      end
    end
    if (win_on) begin
      win_edge++;
      if (cy_v[0] === 1'b1) begin
        win_pulses++;
        if (last_pulse >= 0) check("pulse_spacing", win_edge - last_pulse, 5);
        last_pulse = win_edge;
      end
    end
    if (!r[3] && cy_v[3] === 1'b1) begin
      if (big_first == 0) big_first = k_v[3];
      else if (big_second == 0) big_second = k_v[3];
    end
    if (!r[3] && int'(cnt_big) > int'(big_max)) big_max = cnt_big;
  endtask

  initial begin
    bit found;

    // Reset every instance for three clocks.
    repeat (3) step(4'hF);

    // Release and watch 100 clocks of the cycle=5 instance.
    win_on = 1'b1;
    repeat (100) step(4'h0);
    win_on = 1'b0;
    check("pulses_in_100", win_pulses, 20);

    // One-clock reset while count==3 discards the partial period.
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      if (cnt5 == 32'd3) found = 1'b1;
      else step(4'h0);
    end
    check("wait_count3", found, 1);
    step(4'b0001);
    repeat (4) step(4'h0);
    step(4'h0);
    check("pulse_5_after_release", cy_v[0], 1);

    // Reset on the edge where cy would rise keeps cy low.
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      if (cnt5 == 32'd4) found = 1'b1;
      else step(4'h0);
    end
    check("wait_count4", found, 1);
    step(4'b0001);
    check("rst_on_pulse_cy", cy_v[0], 0);
    check("rst_on_pulse_count", cnt5, 0);

    // cycle=1 / cycle=0: reset drops cy, release raises it again.
    step(4'b0110);
    check("c1_rst_cy", cy_v[1], 0);
    check("c0_rst_cy", cy_v[2], 0);
    step(4'h0);
    check("c1_release_cy", cy_v[1], 1);
    check("c0_release_cy", cy_v[2], 1);

    // Random reset pulses on the short-period instances.
    for (int n = 0; n < 1500; n++) begin
      step({1'b0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 11) == 0)});
    end

    // Let the long-period instance reach past its second pulse.
    for (int n = 0; n < 90_000 && k_v[3] < 83_340; n++) step(4'h0);
    check("big_reached_83340", (k_v[3] >= 83_340), 1);
    check("big_first_pulse", big_first, 41_667);
    check("big_second_pulse", big_second, 83_334);
    check("big_max_count", big_max, 41_666);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_timer
